hoaaned_accumulator: RTL

//  Streaming accumulator built on HOAANED approximate addition: sums a frame of unsigned

---
 rtl/hoaaned_accumulator_if.sv | 44 ++++
 rtl/hoaaned_accumulator.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hoaaned_accumulator_if.sv
// rtl/hoaaned_accumulator_if.sv - operand/result handshake bundle for hoaaned_accumulator
// Purpose: groups the operand input stream and the result output port.
// Parameters: DATA_WIDTH (operand width), ACC_WIDTH (result width).
// Signals:
//   in_valid/in_ready/in_data/in_last  operand beat handshake (producer -> accumulator)
//   out_valid/out_ready                result handshake (accumulator -> consumer)
//   out_data/out_count/out_overflow    frame result, beat count, sticky overflow
//   approx_en                          per-beat approximation select (HOAANED_ACC_BYPASS_EN only)
// Modports: master = producer/consumer side, slave = accumulator side.
interface hoaaned_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [15:0]           out_count;
  logic                  out_overflow;
`ifdef HOAANED_ACC_BYPASS_EN
  logic                  approx_en;

  modport master (
    output in_valid, in_data, in_last, out_ready, approx_en,
    input  in_ready, out_valid, out_data, out_count, out_overflow
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready, approx_en,
    output in_ready, out_valid, out_data, out_count, out_overflow
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_overflow
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_overflow
  );
`endif
endinterface

// File: rtl/hoaaned_accumulator.sv
// rtl/hoaaned_accumulator.sv - streaming frame accumulator using HOAANED approximate addition
// Purpose: sums a frame of unsigned operands; the low IMPRECISE_PART bits use the
//   HOAANED approximate adder, the upper bits are exact. Result handed off over valid/ready.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  hoaaned_accumulator_if.slave (operand stream in, result out)
// Configuration macro: HOAANED_ACC_BYPASS_EN adds bus.approx_en; when it is low an
//   accumulating beat uses the exact ACC_WIDTH-bit add instead.
module hoaaned_accumulator #(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int IMPRECISE_PART = 8
) (
  input logic                  clk,
  input logic                  rst,
  hoaaned_accumulator_if.slave bus
);
  localparam int K = IMPRECISE_PART;
  localparam int N = ACC_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t         state;
  logic [N-1:0]   acc;
  logic [15:0]    count;
  logic           ovf;
  logic           in_ready_q;
  logic           out_valid_q;

  logic [N-1:0]   in_ext;
  logic [N-1:0]   approx_sum;
  logic           approx_carry;
  logic [N-K:0]   hi_sum;
  logic           w;
  logic           p;
  logic [N-1:0]   next_sum;
  logic           next_carry;
  logic           accept;

  assign in_ext = N'(bus.in_data);
  assign accept = bus.in_valid & in_ready_q;

  // HOAANED add of acc and the incoming operand.
  always_comb begin
    approx_sum = '0;
    for (int i = 0; i < K - 2; i++) begin
      approx_sum[i] = 1'b1;
    end
    approx_sum[K-2] = acc[K-2] | in_ext[K-2];
    w = acc[K-1] & in_ext[K-1];
    p = acc[K-2] & in_ext[K-2];
    approx_sum[K-1] = w ? p : (acc[K-1] | in_ext[K-1] | p);
    // Upper part is exact, with w acting as the carry-in from the approximate part.
    hi_sum = {1'b0, acc[N-1:K]} + {1'b0, in_ext[N-1:K]} + {{(N-K){1'b0}}, w};
    approx_sum[N-1:K] = hi_sum[N-K-1:0];
    approx_carry = hi_sum[N-K];
  end

`ifdef HOAANED_ACC_BYPASS_EN
  logic [N:0] exact_sum;
  assign exact_sum = {1'b0, acc} + {1'b0, in_ext};

  always_comb begin
    next_sum   = approx_sum;
    next_carry = approx_carry;
    if (!bus.approx_en) begin
      next_sum   = exact_sum[N-1:0];
      next_carry = exact_sum[N];
    end
  end
`else
  assign next_sum   = approx_sum;
  assign next_carry = approx_carry;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            // First beat of a frame loads exactly; nothing to approximate against.
            acc   <= in_ext;
            count <= 16'd1;
            ovf   <= 1'b0;
            if (bus.in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc   <= next_sum;
            count <= (count == 16'hFFFF) ? count : count + 16'd1;
            ovf   <= ovf | next_carry;
            if (bus.in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = acc;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf;
endmodule
